// File: rtl/clk_div_prog.sv
// Programmable clock divider with 50% duty for odd and even ratios.
// New ratios are staged in a shadow register and take effect only on a period boundary.
module clk_div_prog #(
  parameter int CNT_W    = 8,
  parameter int DIV_INIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             pend,
  output logic             err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_INIT);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_div, w_div_nxt;
  logic [CNT_W-1:0] r_shadow, w_shadow_nxt;
  logic [CNT_W-1:0] w_half;
  logic             r_pend, w_pend_nxt;
  logic             r_err, w_err_nxt;
  logic             r_tick, w_tick_nxt;
  logic             r_pe, w_pe_nxt;
  logic             r_po, w_po_nxt;
  logic             r_n;
  logic             w_boundary, w_apply, w_load_ok, w_load_bad, w_run_nxt, w_p_nxt;

  // Next-state, ratio staging and output-flop inputs
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_apply      = 1'b0;
    w_load_ok    = div_load & (div_val >= CNT_W'(2));
    w_load_bad   = div_load & (div_val <  CNT_W'(2));
    w_boundary   = (r_state == S_RUN) && (r_cnt == (r_div - CNT_W'(1)));
    case (r_state)
      S_IDLE: begin
        w_apply   = r_pend;
        w_cnt_nxt = '0;
        if (en) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_boundary) begin
          w_apply   = r_pend;
          w_cnt_nxt = '0;
          if (en) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_apply) begin
      w_div_nxt = r_shadow;
    end else begin
      w_div_nxt = r_div;
    end

    if (w_load_ok) begin
      w_shadow_nxt = div_val;
      w_pend_nxt   = 1'b1;
    end else begin
      w_shadow_nxt = r_shadow;
      w_pend_nxt   = r_pend & ~w_apply;
    end

    // Even and odd ratios drive separate flops so a ratio switch never glitches the output
    w_err_nxt  = w_load_bad;
    w_run_nxt  = (w_state_nxt == S_RUN);
    w_half     = (w_div_nxt - CNT_W'(1)) >> 1;
    w_p_nxt    = w_run_nxt & (w_cnt_nxt <= w_half);
    w_tick_nxt = w_run_nxt & (w_cnt_nxt == CNT_W'(0));
    w_pe_nxt   = w_p_nxt & ~w_div_nxt[0];
    w_po_nxt   = w_p_nxt &  w_div_nxt[0];
  end

  // Posedge state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_div    <= DIV_RST;
      r_shadow <= DIV_RST;
      r_pend   <= 1'b0;
      r_err    <= 1'b0;
      r_tick   <= 1'b0;
      r_pe     <= 1'b0;
      r_po     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_div    <= w_div_nxt;
      r_shadow <= w_shadow_nxt;
      r_pend   <= w_pend_nxt;
      r_err    <= w_err_nxt;
      r_tick   <= w_tick_nxt;
      r_pe     <= w_pe_nxt;
      r_po     <= w_po_nxt;
    end
  end

  // Half-cycle delayed copy of the odd-ratio phase
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_n <= 1'b0;
    end else begin
      r_n <= r_po;
    end
  end

  assign clk_out = r_pe | (r_po & r_n);
  assign tick    = r_tick;
  assign pend    = r_pend;
  assign err     = r_err;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed, table-driven bench for clk_div_prog.
module tb_clk_div_prog;
  logic       clk = 1'b0;
  logic       rst, en, div_load;
  logic [7:0] div_val;
  logic       clk_out, tick, pend, err;

  int     n_chk  = 0;
  int     n_fail = 0;
  longint t_rise = 0, t_prev_rise = 0, t_fall = 0;

  typedef struct {
    logic       en;
    logic       ld;
    logic [7:0] val;
    logic [3:0] exp;   // {clk_out, tick, pend, err}
  } vec_t;
  vec_t vq[$];

  clk_div_prog #(.CNT_W(8), .DIV_INIT(4)) dut (
    .clk(clk), .rst(rst), .en(en), .div_val(div_val), .div_load(div_load),
    .clk_out(clk_out), .tick(tick), .pend(pend), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk_out) begin t_prev_rise = t_rise; t_rise = $time; end
  always @(negedge clk_out) t_fall = $time;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_val = 8'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic void add(input logic e, input logic l, input logic [7:0] v, input logic [3:0] x);
    vq.push_back('{e, l, v, x});
  endfunction

  function automatic void add_n(input int n, input logic e, input logic [3:0] x);
    for (int i = 0; i < n; i++) add(e, 1'b0, 8'd0, x);
  endfunction

  initial begin
    int ticks;

    // N=4 start, load 6 at cnt=1, illegal load, overwrite 3->8, boundary load, stop/start
    add(1, 0, 0, 4'b1100); add_n(1, 1, 4'b1000); add_n(2, 1, 4'b0000); add(1, 0, 0, 4'b1100);
    add(1, 0, 0, 4'b1000); add(1, 1, 8'd6, 4'b0010); add(1, 0, 0, 4'b0010);
    add(1, 0, 0, 4'b1100); add_n(2, 1, 4'b1000); add_n(3, 1, 4'b0000); add(1, 0, 0, 4'b1100);
    add(1, 1, 8'd1, 4'b1001); add(1, 0, 0, 4'b1000);
    add(1, 1, 8'd3, 4'b0010); add(1, 1, 8'd8, 4'b0010); add(1, 0, 0, 4'b0010);
    add(1, 0, 0, 4'b1100); add_n(3, 1, 4'b1000); add_n(4, 1, 4'b0000); add(1, 0, 0, 4'b1100);
    add_n(3, 1, 4'b1000); add_n(4, 1, 4'b0000);
    add(1, 1, 8'd4, 4'b1110); add_n(3, 1, 4'b1010); add_n(4, 1, 4'b0010);
    add(1, 0, 0, 4'b1100); add(1, 0, 0, 4'b1000); add(1, 0, 0, 4'b0000);
    add_n(3, 0, 4'b0000); add(1, 0, 0, 4'b1100);
    add(1, 0, 0, 4'b1000); add(0, 0, 0, 4'b0000); add(1, 0, 0, 4'b0000); add(1, 0, 0, 4'b1100);

    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_val = 8'd0;
    #48;
    check("reset_outputs", {clk_out, tick, pend, err}, 4'b0000);
    #2 rst = 1'b0;

    foreach (vq[i]) begin
      en = vq[i].en; div_load = vq[i].ld; div_val = vq[i].val;
      step();
      check($sformatf("vec%0d", i), {clk_out, tick, pend, err}, vq[i].exp);
    end

    // Async reset mid-period with a pending ratio
    en = 1'b1; div_load = 1'b1; div_val = 8'd7;
    step();
    div_load = 1'b0;
    check("pre_rst_pend", {clk_out, pend}, 2'b11);
    #2 rst = 1'b1;
    #1 check("rst_async_outputs", {clk_out, tick, pend, err}, 4'b0000);
    en = 1'b0;
    @(negedge clk) rst = 1'b0;
    en = 1'b1;
    step(); check("rst_restart", {clk_out, tick, pend}, 3'b110);
    step(); step(); check("rst_ratio4_low", clk_out, 1'b0);
    step(); step(); check("rst_ratio4_tick", tick, 1'b1);

    // Odd ratio 5 loaded while idle
    pulse_reset();
    div_load = 1'b1; div_val = 8'd5;
    step(); div_load = 1'b0;
    check("odd_pend_set", pend, 1'b1);
    step(); check("odd_pend_applied", pend, 1'b0);
    en = 1'b1;
    step(); check("odd_start", {clk_out, tick}, 2'b01);
    @(negedge clk); #1 check("odd_rise_half", clk_out, 1'b1);
    for (int i = 0; i < 8; i++) step();
    check("odd_high_time", t_fall - t_rise, 32'd25);
    check("odd_period", t_rise - t_prev_rise, 32'd50);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin step(); ticks += int'(tick); end
    check("odd_tick_count", ticks, 32'd2);

    // Maximum ratio 255
    pulse_reset();
    div_load = 1'b1; div_val = 8'd255;
    step(); div_load = 1'b0;
    step(); check("max_pend_applied", pend, 1'b0);
    en = 1'b1;
    step(); check("max_start_tick", tick, 1'b1);
    ticks = 0;
    for (int s = 1; s <= 254; s++) begin
      step();
      ticks += int'(tick);
      if (s == 127) check("max_high_last", clk_out, 1'b1);
      if (s == 128) check("max_low_first", clk_out, 1'b0);
    end
    check("max_no_early_tick", ticks, 32'd0);
    step(); check("max_tick_255", tick, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter CNT_W, default 8; width of the divide-ratio field.
REQ-002 Parameter DIV_INIT, default 4; divide ratio after reset, legal range 2..2^CNT_W-1.
REQ-003 clk  input  1  single system clock; all logic on clk (posedge), plus one negedge flop for odd ratios.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  divider run enable, sampled on posedge clk.
REQ-006 div_val  input  CNT_W  requested divide ratio N.
REQ-007 div_load  input  1  one-cycle strobe; requests that div_val be loaded.
REQ-008 clk_out  output  1  divided clock, period N clk cycles, duty as REQ-013/014.
REQ-009 tick  output  1  one-cycle pulse, high in the cycle clk_out rises.
REQ-010 pend  output  1  high while a loaded ratio waits for a period boundary.
REQ-011 err  output  1  one-cycle pulse flagging an illegal load.

Function
REQ-012 Internal period counter cnt, 0..N-1: increments each enabled posedge; wraps N-1 -> 0 (period boundary).
REQ-013 Even N: clk_out high for cnt 0..N/2-1 and low for N/2..N-1, giving exactly 50% duty; driven from posedge flops only.
REQ-014 Odd N: posedge flop p high for cnt 0..(N-1)/2; negedge flop n = p delayed half a cycle; clk_out = p AND n; high time N/2 clk periods, i.e. 50% duty.
REQ-015 clk_out shall be glitch-free: no combinational path from cnt or inputs to clk_out other than the AND of REQ-014.
REQ-016 tick is registered and high in exactly the posedge cycle in which cnt = 0, with one pulse per output period.
REQ-017 Start: en 0->1 while idle starts a period at the next posedge. cnt = 0, clk_out rises and tick = 1 in that cycle.
REQ-018 Stop: en sampled low mid-period lets the current period complete. At the boundary: enter idle, cnt = 0, clk_out = 0, no tick.
REQ-019 Stop: if en returns high before the boundary, the divider runs continuously with no gap.
REQ-020 Legal load (div_load=1, div_val >= 2): capture div_val into a shadow register; pend = 1 from the next cycle.
REQ-021 The new ratio applies at the first period boundary strictly after the load cycle. A load in the boundary cycle itself waits one more period.
REQ-022 While idle, a pending ratio is applied on the next posedge. pend clears in the cycle the ratio takes effect.
REQ-023 A second legal load while pend = 1 overwrites the shadow register (last wins); pend stays 1.
REQ-024 Illegal load (div_val = 0 or 1): err pulses high for one cycle, the next cycle after the strobe. Shadow, pend and the active ratio are unchanged.
REQ-025 The active ratio never changes mid-period, so no period is ever shorter than min(old N, new N) or partially formed.
REQ-026 Counter and comparisons are unsigned CNT_W bits. N = 2^CNT_W-1 shall produce no overflow.

Reset
REQ-027 rst high asynchronously forces: cnt = 0, p = 0, n = 0, clk_out = 0, tick = 0, pend = 0, err = 0, active ratio = shadow = DIV_INIT, state = idle.
REQ-028 rst asserted mid-period aborts immediately, and any pending load is discarded.
REQ-029 After rst deasserts, behaviour is per REQ-017; the first clk_out rise comes at the first posedge with en = 1.

Verification
REQ-030 Default ratio: rst high 50 ns, en = 1 -> clk_out period 4 clk, high 2 clk; tick every 4th cycle aligned with clk_out rise.
REQ-031 Odd ratio: load div_val = 5 while idle, en = 1 -> period 5 clk, high time 2.5 clk measured edge-to-edge, tick every 5 cycles.
REQ-032 Mid-period reconfig: running N = 4, load 6 at cnt = 1 -> pend = 1 and the current period completes at 4. Next period is 6; pend clears at that boundary.
REQ-033 Illegal and overwrite: load 1 -> err pulse, N unchanged. Load 3 then 8 before the boundary -> next period uses 8.
REQ-034 Stop/start: en low at cnt = 2 (N = 4) -> period completes, clk_out stays 0, no tick. en high -> clk_out rises on the next posedge.
REQ-035 Async reset mid-period with pend = 1 -> outputs 0 immediately, ratio returns to 4, and the pending value is lost.
